// File: rtl/usb_nrzi_tx.sv
// usb_nrzi_tx: USB LS/FS line driver with SYNC, NRZI, bit stuffing, EOP and underrun abort
module usb_nrzi_tx #(
   parameter int SYNC_EN    = 1,
   parameter int STUFF_LEN  = 6,
   parameter int SE0_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_L,
   input  logic data_bit,
   input  logic data_valid,
   input  logic data_start,
   input  logic data_end,
   output logic ready,
   output logic d_p,
   output logic d_m,
   output logic sending,
   output logic underrun
);
   typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
   localparam logic [1:0] J = 2'b10, K = 2'b01, SE0 = 2'b00;
   localparam logic [3:0] STUFF_MAX = 4'(STUFF_LEN);
   localparam logic [2:0] SE0_LAST = 3'(SE0_CYCLES - 1);
   state_t state, state_n;
   logic [1:0] line, line_n, tog;
   logic [3:0] ones_cnt, ones_n, ones_inc;
   logic [2:0] sync_cnt, sync_n, se0_cnt, se0_n;
   logic end_pending, end_n, underrun_n;
   assign tog = line == J ? K : J;
   assign ones_inc = ones_cnt + 4'd1;
   assign ready = state == DATA;
   assign d_p = line[1];
   assign d_m = line[0];
   always_comb begin
      state_n = state;
      line_n = J;
      ones_n = ones_cnt;
      sync_n = sync_cnt;
      se0_n = se0_cnt;
      end_n = end_pending;
      underrun_n = 1'b0;
      case (state)
         IDLE: if (data_valid && data_start) begin
            state_n = SYNC_EN != 0 ? SYNC : DATA;
            ones_n = 4'd0;
         end
         SYNC: begin
            line_n = sync_cnt == 3'd7 ? line : tog;
            sync_n = sync_cnt == 3'd7 ? 3'd0 : sync_cnt + 3'd1;
            ones_n = sync_cnt == 3'd7 ? 4'd1 : 4'd0;
            state_n = sync_cnt == 3'd7 ? DATA : SYNC;
         end
         DATA: begin
            // an underrun holds the line for one symbol, then closes the packet
            line_n = data_valid && !data_bit ? tog : line;
            ones_n = data_valid && data_bit ? ones_inc : 4'd0;
            underrun_n = !data_valid;
            end_n = data_end;
            state_n = !data_valid ? EOP_SE0 :
                      data_bit && ones_inc == STUFF_MAX ? STUFF :
                      data_end ? EOP_SE0 : DATA;
         end
         STUFF: begin
            line_n = tog;
            ones_n = 4'd0;
            end_n = 1'b0;
            state_n = end_pending ? EOP_SE0 : DATA;
         end
         EOP_SE0: begin
            line_n = SE0;
            se0_n = se0_cnt == SE0_LAST ? 3'd0 : se0_cnt + 3'd1;
            state_n = se0_cnt == SE0_LAST ? EOP_J : EOP_SE0;
         end
         EOP_J: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_L) begin
      if (!rst_L) begin
         state <= IDLE;
         line <= J;
         sending <= 1'b0;
         underrun <= 1'b0;
         ones_cnt <= 4'd0;
         sync_cnt <= 3'd0;
         se0_cnt <= 3'd0;
         end_pending <= 1'b0;
      end else begin
         state <= state_n;
         line <= line_n;
         sending <= state != IDLE;
         underrun <= underrun_n;
         ones_cnt <= ones_n;
         sync_cnt <= sync_n;
         se0_cnt <= se0_n;
         end_pending <= end_n;
      end
   end
endmodule
